prog_reg_bank: RTL and testbench

- Parametrised successor to the fixed-field serial programmer. Configuration registers are held as N_REGS addressed words of REG_W bits.
- SCLK/SDI/CS are oversampled in the CLK_24M domain, so the block has no second clock.
- Adds parity-checked write frames, readback over SDO, shadow-and-commit on CS release, per-register update strobes and a sticky frame error flag.
- Sits between the chip programming pins and the analog-control/converter configuration outputs at DOGX top level.

---
 rtl/prog_reg_bank_pkg.sv | 21 ++
 rtl/prog_reg_bank_if.sv | 11 +
 rtl/prog_input_sync.sv | 51 +++++
 rtl/prog_reg_bank.sv | 147 ++++++++++++++
 tb/tb_prog_reg_bank.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/prog_reg_bank_pkg.sv
// Shared types and helpers for the serial configuration register bank.
package prog_reg_pkg;
  typedef enum logic [2:0] {IDLE, CMD, DATA, PAR, DONE} prog_state_t;

  // Wire order, MSB first: rw | addr | data | par
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_REG_W    = 24;
  localparam int DEF_FRAME_W  = 2 + DEF_ADDR_W + DEF_REG_W;
  localparam int DEF_CMD_W    = 1 + DEF_ADDR_W;
  localparam int DEF_PAR_POS  = 0;
  localparam int DEF_DATA_LSB = 1;
  localparam int DEF_ADDR_LSB = 1 + DEF_REG_W;
  localparam int DEF_RW_POS   = DEF_FRAME_W - 1;

  localparam int PAR_MAX_W = 128;

  // Callers zero-extend; padding does not change the XOR.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/prog_reg_bank_if.sv
// Chip programming pins: SCLK/SDI/CS in, SDO/SDO_OE back out.
interface prog_reg_bank_if;
  logic SCLK;
  logic SDI;
  logic CS;
  logic SDO;
  logic SDO_OE;

  modport slave  (input SCLK, SDI, CS, output SDO, SDO_OE);
  modport master (output SCLK, SDI, CS, input SDO, SDO_OE);
endinterface

// File: rtl/prog_input_sync.sv
// Synchronises the serial pins into CLK_24M and emits registered edge pulses.
module prog_input_sync
  import prog_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK_24M,
  input  logic reset,
  input  logic sclk_i,
  input  logic sdi_i,
  input  logic cs_i,
  output logic sdi_o,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);
  // {cs, sclk, sdi}; CS parked high so reset release cannot fake a cs_fall
  localparam logic [2:0] IDLE_LVL = 3'b100;

  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0] last_q, last_d;
  logic [3:0] edge_q, edge_d;
  logic [2:0] lvl;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {cs_i, sclk_i, sdi_i};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    lvl    = sync_q[SYNC_STAGES-1];
    last_d = lvl;
    edge_d = {lvl[2] & ~last_q[2], ~lvl[2] & last_q[2],
              ~lvl[1] & last_q[1], lvl[1] & ~last_q[1]};
  end

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_LVL}};
      last_q <= IDLE_LVL;
      edge_q <= '0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      edge_q <= edge_d;
    end
  end

  // last_q[0] carries SDI with the same delay as the edge pulses
  assign sdi_o = last_q[0];
  assign {cs_rise, cs_fall, sclk_fall, sclk_rise} = edge_q;
endmodule

// File: rtl/prog_reg_bank.sv
// Serial-programmed configuration register bank with parity, readback and commit on CS release.
module prog_reg_bank
  import prog_reg_pkg::*;
#(
  parameter int N_REGS      = 8,
  parameter int REG_W       = DEF_REG_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter logic [N_REGS*REG_W-1:0] RESET_VAL = '0
) (
  input  logic                    CLK_24M,
  input  logic                    reset,
  prog_reg_bank_if.slave          pins,
  input  logic                    err_clr,
  output logic [N_REGS*REG_W-1:0] cfg_regs,
  output logic                    cfg_valid,
  output logic [ADDR_W-1:0]       cfg_addr,
  output logic                    frame_err
);
  localparam int FRAME_W  = 2 + ADDR_W + REG_W;
  localparam int CMD_W    = 1 + ADDR_W;
  localparam int DATA_END = CMD_W + REG_W;
  localparam int ADDR_LSB = 1 + REG_W;
  localparam int CNT_W    = $clog2(FRAME_W + 1);

  logic sdi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  prog_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK_24M(CLK_24M), .reset(reset),
    .sclk_i(pins.SCLK), .sdi_i(pins.SDI), .cs_i(pins.CS),
    .sdi_o(sdi_s), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .cs_fall(cs_fall), .cs_rise(cs_rise)
  );

  prog_state_t               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [FRAME_W-1:0]        sr_q, sr_d, sr_shift;
  logic                      ovf_q, ovf_d, rd_q, rd_d, rd_par_q, rd_par_d;
  logic [REG_W-1:0]          rd_sh_q, rd_sh_d, rd_word;
  logic                      sdo_q, sdo_d, sdo_oe_q, sdo_oe_d;
  logic [N_REGS*REG_W-1:0]   regs_q, regs_d;
  logic                      valid_q, valid_d, err_q, err_d, err_set;
  logic [ADDR_W-1:0]         caddr_q, caddr_d, f_addr, new_addr;

  always_comb begin
    state_d  = state_q;   cnt_d    = cnt_q;    sr_d    = sr_q;
    ovf_d    = ovf_q;     rd_d     = rd_q;     rd_sh_d = rd_sh_q;
    rd_par_d = rd_par_q;  sdo_d    = sdo_q;    sdo_oe_d = sdo_oe_q;
    regs_d   = regs_q;    valid_d  = 1'b0;     caddr_d = caddr_q;
    err_set  = 1'b0;
    sr_shift = {sr_q[FRAME_W-2:0], sdi_s};
    cnt_inc  = cnt_q + CNT_W'(1);
    f_addr   = sr_q[ADDR_LSB +: ADDR_W];
    new_addr = sr_shift[ADDR_W-1:0];
    rd_word  = '0;
    for (int i = 0; i < N_REGS; i++)
      if (new_addr == ADDR_W'(i)) rd_word = regs_q[i*REG_W +: REG_W];

    // CS release outranks any SCLK edge landing in the same cycle
    if (cs_rise && state_q != IDLE) begin
      state_d  = IDLE;
      sdo_d    = 1'b0;
      sdo_oe_d = 1'b0;
      if (cnt_q != '0) begin
        if (cnt_q != CNT_W'(FRAME_W) || ovf_q || int'(f_addr) >= N_REGS) begin
          err_set = 1'b1;
        end else if (!sr_q[FRAME_W-1]) begin
          if (even_parity(PAR_MAX_W'(sr_q))) begin
            err_set = 1'b1;
          end else begin
            for (int i = 0; i < N_REGS; i++)
              if (f_addr == ADDR_W'(i)) regs_d[i*REG_W +: REG_W] = sr_q[REG_W:1];
            valid_d = 1'b1;
            caddr_d = f_addr;
          end
        end
      end
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          sr_d    = '0;
          ovf_d   = 1'b0;
          rd_d    = 1'b0;
        end
        CMD: if (sclk_rise) begin
          sr_d  = sr_shift;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(CMD_W)) begin
            state_d  = DATA;
            rd_d     = sr_shift[ADDR_W];
            rd_sh_d  = rd_word;
            rd_par_d = even_parity(PAR_MAX_W'(rd_word));
          end
        end
        DATA: begin
          if (sclk_rise) begin
            sr_d  = sr_shift;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DATA_END)) state_d = PAR;
          end
          if (sclk_fall && rd_q) begin
            sdo_d    = rd_sh_q[REG_W-1];
            rd_sh_d  = {rd_sh_q[REG_W-2:0], 1'b0};
            sdo_oe_d = 1'b1;
          end
        end
        PAR: begin
          if (sclk_rise) begin
            sr_d    = sr_shift;
            cnt_d   = cnt_inc;
            state_d = DONE;
          end
          if (sclk_fall && rd_q) sdo_d = rd_par_q;
        end
        DONE: if (sclk_rise) ovf_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      state_q <= IDLE;  cnt_q  <= '0;   sr_q    <= '0;
      ovf_q   <= 1'b0;  rd_q   <= 1'b0; rd_sh_q <= '0;
      rd_par_q <= 1'b0; sdo_q  <= 1'b0; sdo_oe_q <= 1'b0;
      regs_q  <= RESET_VAL;
      valid_q <= 1'b0;  caddr_q <= '0;  err_q   <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q  <= cnt_d;  sr_q    <= sr_d;
      ovf_q   <= ovf_d;    rd_q   <= rd_d;   rd_sh_q <= rd_sh_d;
      rd_par_q <= rd_par_d; sdo_q <= sdo_d;  sdo_oe_q <= sdo_oe_d;
      regs_q  <= regs_d;
      valid_q <= valid_d;  caddr_q <= caddr_d; err_q <= err_d;
    end
  end

  assign pins.SDO    = sdo_q & sdo_oe_q;
  assign pins.SDO_OE = sdo_oe_q;
  assign cfg_regs    = regs_q;
  assign cfg_valid   = valid_q;
  assign cfg_addr    = caddr_q;
  assign frame_err   = err_q;
endmodule

// File: tb/tb_prog_reg_bank.sv
// Scoreboard bench for prog_reg_bank: serial master, commit monitor, readback collector.
module tb_prog_reg_bank;
  localparam int NR = 6, W = 24, AW = 3, SS = 2, FW = 2 + AW + W, HALF = 4;
  localparam logic [NR*W-1:0] RV = {24'h5A5A05, 24'h040404, 24'h030303,
                                    24'h020202, 24'h010101, 24'h000000};

  typedef struct { logic [AW-1:0] a; logic [W-1:0] d; } commit_t;

  logic clk = 1'b0, reset = 1'b1, err_clr = 1'b0;
  logic [NR*W-1:0] cfg_regs;
  logic cfg_valid, frame_err, prev_valid = 1'b0;
  logic [AW-1:0] cfg_addr;
  longint cyc = 0, cs_rise_cyc = 0;
  int n_tot = 0, n_bad = 0;
  commit_t exp_q[$];
  commit_t e_mon;
  logic [W:0] rd_exp_q[$];
  logic [W-1:0] mdl [NR];

  prog_reg_bank_if pins();

  prog_reg_bank #(.N_REGS(NR), .REG_W(W), .ADDR_W(AW), .SYNC_STAGES(SS), .RESET_VAL(RV)) dut (
    .CLK_24M(clk), .reset(reset), .pins(pins), .err_clr(err_clr),
    .cfg_regs(cfg_regs), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .frame_err(frame_err)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Commit monitor: each cfg_valid pulse consumes one expected commit
  always @(negedge clk) begin
    if (cfg_valid) begin
      chk("vld_1cyc", 64'(prev_valid), 64'(0));
      chk("latency", 64'(cyc - cs_rise_cyc), 64'(SS + 2));
      if (exp_q.size() == 0) chk("unexp_commit", 64'(1), 64'(0));
      else begin
        e_mon = exp_q.pop_front();
        chk("cfg_addr", 64'(cfg_addr), 64'(e_mon.a));
        chk("cfg_reg", 64'(cfg_regs[e_mon.a*W +: W]), 64'(e_mon.d));
      end
    end
    prev_valid <= cfg_valid;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [FW-1:0] mkf(input logic rw, input logic [AW-1:0] a,
                                        input logic [W-1:0] d, input logic flip);
    logic [FW-2:0] b;
    b = {rw, a, d};
    return {b, ^b ^ flip};
  endfunction

  task automatic shift_bits(input logic [63:0] bits, input int n,
                            output logic [W:0] rd, output logic [31:0] oe);
    rd = '0; oe = '0;
    pins.CS = 1'b0; tick(HALF);
    for (int i = 0; i < n; i++) begin
      pins.SDI = bits[n-1-i]; tick(HALF);
      if (i >= 1 + AW) rd = {rd[W-1:0], pins.SDO};
      oe = {oe[30:0], pins.SDO_OE};
      pins.SCLK = 1'b1; tick(HALF); pins.SCLK = 1'b0;
    end
    tick(HALF);
  endtask

  task automatic end_frame(input bit stray, input bit clr_same);
    if (stray) pins.SCLK = 1'b1;
    pins.CS = 1'b1;
    cs_rise_cyc = cyc;
    if (clr_same) begin tick(SS + 1); err_clr = 1'b1; tick(1); err_clr = 1'b0; end
    tick(SS + 6);
    pins.SCLK = 1'b0;
    tick(HALF);
  endtask

  task automatic frame(input logic [63:0] bits, input int n, input bit stray, input bit clr_same,
                       output logic [W:0] rd, output logic [31:0] oe);
    shift_bits(bits, n, rd, oe);
    end_frame(stray, clr_same);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input bit flip, input bit stray);
    logic [W:0] rd; logic [31:0] oe; commit_t c;
    if (!flip && int'(a) < NR) begin
      c.a = a; c.d = d;
      exp_q.push_back(c);
      mdl[int'(a)] = d;
    end
    frame(64'(mkf(1'b0, a, d, flip)), FW, stray, 1'b0, rd, oe);
  endtask

  task automatic rdf(input logic [AW-1:0] a);
    logic [W:0] rd, e; logic [31:0] oe; logic [W-1:0] wd;
    wd = (int'(a) < NR) ? mdl[int'(a)] : '0;
    rd_exp_q.push_back({wd, ^wd});
    frame(64'(mkf(1'b1, a, '0, 1'b0)), FW, 1'b0, 1'b0, rd, oe);
    e = rd_exp_q.pop_front();
    chk("rd_data", 64'(rd), 64'(e));
    chk("rd_oe", 64'(oe), 64'h01FF_FFFF);
  endtask

  task automatic clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    chk("err_clr", 64'(frame_err), 64'(0));
  endtask

  task automatic check_all(input string tag, input logic err);
    chk({tag, "_err"}, 64'(frame_err), 64'(err));
    chk({tag, "_pend"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_oe"}, 64'(pins.SDO_OE), 64'(0));
    for (int i = 0; i < NR; i++) chk({tag, "_reg"}, 64'(cfg_regs[i*W +: W]), 64'(mdl[i]));
  endtask

  initial begin
    logic [W:0] rd; logic [31:0] oe; logic [FW-1:0] f;
    pins.CS = 1'b1; pins.SCLK = 1'b0; pins.SDI = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = RV[i*W +: W];
    tick(5); reset = 1'b0; tick(2);
    chk("rst_valid", 64'(cfg_valid), 64'(0));
    chk("rst_addr", 64'(cfg_addr), 64'(0));
    chk("rst_sdo", 64'(pins.SDO), 64'(0));
    check_all("rst", 1'b0);

    wr(3'd5, 24'hA5C3F0, 1'b0, 1'b0);  check_all("wr5", 1'b0);
    chk("addr5", 64'(cfg_addr), 64'(5));
    wr(3'd5, 24'hA5C3F0, 1'b1, 1'b0);  check_all("badpar", 1'b1);
    clr();

    rdf(3'd5); check_all("rd5", 1'b0);
    rdf(3'd1); check_all("rd1", 1'b0);
    rdf(3'd7); check_all("rd7", 1'b1);
    clr();

    wr(3'd6, 24'h111111, 1'b0, 1'b0); check_all("wr6", 1'b1);
    clr();
    f = mkf(1'b0, 3'd2, 24'h00F00D, 1'b0);
    frame(64'(f >> 1), FW - 1, 1'b0, 1'b1, rd, oe); check_all("short", 1'b1);
    clr();
    frame({34'b0, f, 1'b0}, FW + 1, 1'b0, 1'b0, rd, oe); check_all("long", 1'b1);
    clr();
    wr(3'd2, 24'h00F00D, 1'b0, 1'b0); check_all("wr2", 1'b0);

    f = mkf(1'b0, 3'd4, 24'hBEEF01, 1'b0);
    shift_bits(64'(f >> (FW - 15)), 15, rd, oe);
    reset = 1'b1; pins.CS = 1'b1; tick(SS + 4); reset = 1'b0; tick(2);
    for (int i = 0; i < NR; i++) mdl[i] = RV[i*W +: W];
    chk("midrst_addr", 64'(cfg_addr), 64'(0));
    check_all("midrst", 1'b0);
    wr(3'd3, 24'h777777, 1'b0, 1'b0); check_all("wr3", 1'b0);

    repeat (10) begin pins.SCLK = 1'b1; tick(HALF); pins.SCLK = 1'b0; tick(HALF); end
    pins.CS = 1'b0; tick(HALF); pins.CS = 1'b1; tick(SS + 6);
    check_all("cshigh", 1'b0);

    wr(3'd0, 24'h123456, 1'b0, 1'b1); check_all("stray", 1'b0);
    chk("addr0", 64'(cfg_addr), 64'(0));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
